// File: rtl/ctrl_bubble_reg.sv
// ID/EX control-word register with load-use hazard detection, multi-cycle
// bubble insertion, branch flush, downstream hold and a saturating bubble counter.
module ctrl_bubble_reg #(
    parameter int unsigned CTRL_W      = 9,
    parameter int unsigned MEMREAD_BIT = 4,
    parameter int unsigned REG_W       = 5,
    parameter int unsigned LOAD_STALL  = 1,
    parameter int unsigned PERF_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  ex_rt,
    input  logic              flush,
    input  logic              ext_stall,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              bubble,
    output logic              pc_write,
    output logic              ifid_write,
    output logic [PERF_W-1:0] bubble_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [2:0]        STALL_INIT = 3'(LOAD_STALL - 1);
    localparam logic [PERF_W-1:0] PERF_ONE   = PERF_W'(1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              bubble_q, bubble_d;
    logic [PERF_W-1:0] perf_q, perf_d;

    logic ex_load;
    logic hazard;
    logic freeze;

    // A bubble in EX carries no real load, so it can never create a hazard.
    assign ex_load = ctrl_q[MEMREAD_BIT] & ~bubble_q;
    assign hazard  = ex_load & id_valid & (ex_rt != '0) &
                     ((ex_rt == id_rs) | (ex_rt == id_rt));
    assign freeze  = ((state_q == RUN) & hazard) | (state_q == STALL);

    assign pc_write   = ~ext_stall & (flush | ~freeze);
    assign ifid_write = ~ext_stall & (flush | ~freeze);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ctrl_d   = ctrl_q;
        bubble_d = bubble_q;
        perf_d   = perf_q;

        if (flush) begin
            ctrl_d   = '0;
            bubble_d = 1'b1;
            state_d  = RUN;
            cnt_d    = '0;
        end else if (ext_stall) begin
            // everything holds, including the remaining stall count
        end else if (freeze) begin
            ctrl_d   = '0;
            bubble_d = 1'b1;
            if (perf_q != '1) begin
                perf_d = perf_q + PERF_ONE;
            end
            if (state_q == RUN) begin
                if (LOAD_STALL > 1) begin
                    state_d = STALL;
                    cnt_d   = STALL_INIT;
                end
            end else if (cnt_q == 3'd1) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end else begin
            ctrl_d   = ctrl_in;
            bubble_d = ~id_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            ctrl_q   <= '0;
            bubble_q <= 1'b1;
            perf_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
            bubble_q <= bubble_d;
            perf_q   <= perf_d;
        end
    end

    assign ctrl_out   = ctrl_q;
    assign bubble     = bubble_q;
    assign bubble_cnt = perf_q;

endmodule

// File: tb/tb_ctrl_bubble_reg.sv
// Directed bench for ctrl_bubble_reg: one instance with LOAD_STALL=1 and a
// 2-bit counter (saturation), one with LOAD_STALL=3 for multi-cycle stalls.
module tb_ctrl_bubble_reg;

    logic       clk;
    logic       reset;
    logic [8:0] ctrl_in;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       flush, ext_stall;

    logic [8:0]  c1_ctrl, c3_ctrl;
    logic        c1_bub, c3_bub, c1_pw, c3_pw, c1_iw, c3_iw;
    logic [1:0]  c1_cnt;
    logic [15:0] c3_cnt;

    int n_vec = 0;
    int n_bad = 0;

    ctrl_bubble_reg #(.LOAD_STALL(1), .PERF_W(2)) dut1 (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt), .flush(flush),
        .ext_stall(ext_stall), .ctrl_out(c1_ctrl), .bubble(c1_bub),
        .pc_write(c1_pw), .ifid_write(c1_iw), .bubble_cnt(c1_cnt)
    );

    ctrl_bubble_reg #(.LOAD_STALL(3), .PERF_W(16)) dut3 (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt), .flush(flush),
        .ext_stall(ext_stall), .ctrl_out(c3_ctrl), .bubble(c3_bub),
        .pc_write(c3_pw), .ifid_write(c3_iw), .bubble_cnt(c3_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  ci;
        logic        v;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  ert;
        logic        fl;
        logic        es;
        logic        pw;
        logic [8:0]  co;
        logic        bub;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[17];

    task automatic drive(input logic [8:0] ci, input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] ert,
                         input logic fl, input logic es);
        ctrl_in   = ci;
        id_valid  = v;
        id_rs     = rs;
        id_rt     = rt;
        ex_rt     = ert;
        flush     = fl;
        ext_stall = es;
    endtask

    task automatic compare(input string name, input logic pw, input logic iw,
                           input logic [8:0] c, input logic b, input logic [15:0] n,
                           input logic exp_pw, input logic [8:0] exp_c,
                           input logic exp_b, input logic [15:0] exp_n);
        n_vec++;
        if (pw !== exp_pw || iw !== exp_pw || c !== exp_c || b !== exp_b || n !== exp_n) begin
            n_bad++;
            $display("FAIL %s: got pc_write=%b ifid_write=%b ctrl_out=%h bubble=%b bubble_cnt=%0d, need pc/ifid=%b ctrl_out=%h bubble=%b bubble_cnt=%0d",
                     name, pw, iw, c, b, n, exp_pw, exp_c, exp_b, exp_n);
        end
    endtask

    // Entered at a negedge with inputs set: samples the write enables before
    // the rising edge and the registered outputs just after it.
    task automatic run_cyc(input string name, input bit sel3, input logic exp_pw,
                           input logic [8:0] exp_c, input logic exp_b,
                           input logic [15:0] exp_n);
        logic pw, iw, b;
        logic [8:0] c;
        logic [15:0] n;
        #1;
        pw = sel3 ? c3_pw : c1_pw;
        iw = sel3 ? c3_iw : c1_iw;
        @(posedge clk);
        #1;
        c = sel3 ? c3_ctrl : c1_ctrl;
        b = sel3 ? c3_bub : c1_bub;
        n = sel3 ? c3_cnt : {14'b0, c1_cnt};
        compare(name, pw, iw, c, b, n, exp_pw, exp_c, exp_b, exp_n);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(9'h000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        compare("reset_ls1", c1_pw, c1_iw, c1_ctrl, c1_bub, {14'b0, c1_cnt},
                1'b1, 9'h000, 1'b1, 16'd0);
        compare("reset_ls3", c3_pw, c3_iw, c3_ctrl, c3_bub, c3_cnt,
                1'b1, 9'h000, 1'b1, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary, required completion");
        $fatal(1);
    end

    initial begin
        //            ci      v  rs rt ert fl es  pw co      bub cnt
        tbl[0]  = '{9'h1A3, 1, 1, 2, 0, 0, 0,   1, 9'h1A3, 0, 0};
        tbl[1]  = '{9'h010, 1, 1, 2, 9, 0, 0,   1, 9'h010, 0, 0};
        tbl[2]  = '{9'h1A3, 1, 5, 6, 5, 0, 0,   0, 9'h000, 1, 1};
        tbl[3]  = '{9'h1A3, 1, 5, 6, 5, 0, 0,   1, 9'h1A3, 0, 1};
        tbl[4]  = '{9'h010, 1, 1, 2, 3, 0, 0,   1, 9'h010, 0, 1};
        tbl[5]  = '{9'h010, 1, 0, 0, 0, 0, 0,   1, 9'h010, 0, 1};
        tbl[6]  = '{9'h010, 1, 3, 3, 7, 0, 0,   1, 9'h010, 0, 1};
        tbl[7]  = '{9'h1A3, 1, 7, 0, 7, 1, 0,   1, 9'h000, 1, 1};
        tbl[8]  = '{9'h010, 1, 0, 0, 4, 0, 0,   1, 9'h010, 0, 1};
        tbl[9]  = '{9'h1A3, 0, 4, 0, 4, 0, 0,   1, 9'h1A3, 1, 1};
        tbl[10] = '{9'h0FF, 1, 1, 1, 2, 0, 1,   0, 9'h1A3, 1, 1};
        tbl[11] = '{9'h0FF, 1, 1, 1, 2, 0, 0,   1, 9'h0FF, 0, 1};
        tbl[12] = '{9'h1A3, 1, 8, 2, 2, 0, 0,   0, 9'h000, 1, 2};
        tbl[13] = '{9'h010, 1, 2, 2, 2, 0, 0,   1, 9'h010, 0, 2};
        tbl[14] = '{9'h010, 1, 6, 1, 6, 0, 0,   0, 9'h000, 1, 3};
        tbl[15] = '{9'h010, 1, 6, 1, 6, 0, 0,   1, 9'h010, 0, 3};
        tbl[16] = '{9'h010, 1, 6, 1, 6, 0, 0,   0, 9'h000, 1, 3};

        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].ci, tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].ert, tbl[i].fl, tbl[i].es);
            run_cyc($sformatf("ls1_vec%0d", i), 1'b0, tbl[i].pw, tbl[i].co, tbl[i].bub, tbl[i].cnt);
        end

        // LOAD_STALL=3: three consecutive bubbles, then the ID instruction passes.
        do_reset();
        drive(9'h010, 1, 1, 1, 0, 0, 0);
        run_cyc("ls3_load", 1'b1, 1'b1, 9'h010, 1'b0, 16'd0);
        drive(9'h1A3, 1, 5, 0, 5, 0, 0);
        run_cyc("ls3_frz1", 1'b1, 1'b0, 9'h000, 1'b1, 16'd1);
        run_cyc("ls3_frz2", 1'b1, 1'b0, 9'h000, 1'b1, 16'd2);
        run_cyc("ls3_frz3", 1'b1, 1'b0, 9'h000, 1'b1, 16'd3);
        run_cyc("ls3_pass", 1'b1, 1'b1, 9'h1A3, 1'b0, 16'd3);

        // ext_stall for two cycles with two stall cycles remaining.
        do_reset();
        drive(9'h010, 1, 1, 1, 0, 0, 0);
        run_cyc("es_load", 1'b1, 1'b1, 9'h010, 1'b0, 16'd0);
        drive(9'h1A3, 1, 5, 0, 5, 0, 0);
        run_cyc("es_frz1", 1'b1, 1'b0, 9'h000, 1'b1, 16'd1);
        drive(9'h1A3, 1, 5, 0, 5, 0, 1);
        run_cyc("es_hold1", 1'b1, 1'b0, 9'h000, 1'b1, 16'd1);
        run_cyc("es_hold2", 1'b1, 1'b0, 9'h000, 1'b1, 16'd1);
        drive(9'h1A3, 1, 5, 0, 5, 0, 0);
        run_cyc("es_frz2", 1'b1, 1'b0, 9'h000, 1'b1, 16'd2);
        run_cyc("es_frz3", 1'b1, 1'b0, 9'h000, 1'b1, 16'd3);
        run_cyc("es_pass", 1'b1, 1'b1, 9'h1A3, 1'b0, 16'd3);

        // Asynchronous reset in the middle of a stall.
        do_reset();
        drive(9'h010, 1, 1, 1, 0, 0, 0);
        run_cyc("mr_load", 1'b1, 1'b1, 9'h010, 1'b0, 16'd0);
        drive(9'h1A3, 1, 5, 0, 5, 0, 0);
        run_cyc("mr_frz1", 1'b1, 1'b0, 9'h000, 1'b1, 16'd1);
        #1 reset = 1'b1;
        #1;
        compare("mr_async", c3_pw, c3_iw, c3_ctrl, c3_bub, c3_cnt, 1'b1, 9'h000, 1'b1, 16'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        run_cyc("mr_pass", 1'b1, 1'b1, 9'h1A3, 1'b0, 16'd0);

        // Flush during a stall returns to RUN without counting a bubble.
        drive(9'h010, 1, 1, 1, 0, 0, 0);
        run_cyc("sf_load", 1'b1, 1'b1, 9'h010, 1'b0, 16'd0);
        drive(9'h1A3, 1, 5, 0, 5, 0, 0);
        run_cyc("sf_frz1", 1'b1, 1'b0, 9'h000, 1'b1, 16'd1);
        drive(9'h1A3, 1, 5, 0, 5, 1, 0);
        run_cyc("sf_flush", 1'b1, 1'b1, 9'h000, 1'b1, 16'd1);
        drive(9'h1A3, 1, 5, 0, 5, 0, 0);
        run_cyc("sf_pass", 1'b1, 1'b1, 9'h1A3, 1'b0, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
